// File: rtl/pc_pkg.sv
// Shared action type and priority select for the program counter with return stack.
package pc_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_INC,
        ACT_LD,
        ACT_CALL,
        ACT_RET
    } action_e;

    // Fixed priority ret > call > ld > inc > hold; reset is handled by the registers.
    function automatic action_e select_action(input logic ret, input logic call,
                                              input logic ld, input logic inc);
        if (ret)       return ACT_RET;
        else if (call) return ACT_CALL;
        else if (ld)   return ACT_LD;
        else if (inc)  return ACT_INC;
        else           return ACT_HOLD;
    endfunction

endpackage

// File: rtl/reg_n.sv
// WIDTH-bit register with load enable and synchronous reset-to-value.
module reg_n #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            data_q <= RESET_VAL;
        else if (en_i)
            data_q <= d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/pc_stack.sv
// Program counter with return-address stack: hold, inc, load, call and return,
// with sticky overflow/underflow flags.
module pc_stack
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in,
    input  logic                     ld,
    input  logic                     inc,
    input  logic                     call,
    input  logic                     ret,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    action_e          act;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ret_addr, top_entry;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             is_full, is_empty, push;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] stack_q [DEPTH];

    assign act       = select_action(ret, call, ld, inc);
    assign is_full   = (count_q == CW'(DEPTH));
    assign is_empty  = (count_q == '0);
    assign ret_addr  = pc_q + WIDTH'(1);
    assign wr_idx    = count_q[AW-1:0];
    assign rd_idx    = wr_idx - AW'(1);
    assign top_entry = stack_q[rd_idx];
    assign push      = (act == ACT_CALL) && !is_full && !reset;

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        unique case (act)
            ACT_RET: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    pc_d    = top_entry;
                    count_d = count_q - CW'(1);
                end
            end
            ACT_CALL: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    pc_d    = in;
                    count_d = count_q + CW'(1);
                end
            end
            ACT_LD:   pc_d = in;
            ACT_INC:  pc_d = pc_q + WIDTH'(1);
            default:  ;
        endcase
    end

    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            wr_en[i] = push && (wr_idx == AW'(i));
    end

    reg_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VEC)) u_pc (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (1'b1),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    // Stack entries are never reset; their contents are meaningless once count is cleared.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stack
        reg_n #(.WIDTH(WIDTH), .RESET_VAL('0)) u_entry (
            .clk_i (clk),
            .rst_i (1'b0),
            .en_i  (wr_en[g]),
            .d_i   (ret_addr),
            .q_o   (stack_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign out   = pc_q;
    assign count = count_q;
    assign full  = is_full;
    assign empty = is_empty;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: queue-based reference model checked every cycle,
// plus hand-computed expectations at key points.
module tb_pc_stack;

    localparam int unsigned      W  = 16;
    localparam int unsigned      D  = 8;
    localparam logic [W-1:0]     RV = 16'h0100;

    logic         clk = 1'b0;
    logic         rst_s = 1'b0, ld_s = 1'b0, inc_s = 1'b0, call_s = 1'b0, ret_s = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] out_w;
    logic [3:0]   count_w;
    logic         full_w, empty_w, ovf_w, unf_w;

    int vectors = 0;
    int errs    = 0;
    bit live    = 1'b0;

    logic [W-1:0] m_pc;
    logic [W-1:0] m_stk[$];
    logic         m_ovf, m_unf;

    pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(RV)) dut (
        .clk   (clk),
        .reset (rst_s),
        .in    (din),
        .ld    (ld_s),
        .inc   (inc_s),
        .call  (call_s),
        .ret   (ret_s),
        .out   (out_w),
        .count (count_w),
        .full  (full_w),
        .empty (empty_w),
        .ovf   (ovf_w),
        .unf   (unf_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference behaviour: stack as a queue, back = top.
    task automatic model(input logic r, input logic c, input logic rt, input logic l,
                         input logic i, input logic [W-1:0] v);
        logic [W-1:0] nxt;
        if (r) begin
            m_pc = RV; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (rt) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (c) begin
            if (m_stk.size() == D) m_ovf = 1'b1;
            else begin
                nxt = m_pc + 16'd1;
                m_stk.push_back(nxt);
                m_pc = v;
            end
        end else if (l) begin
            m_pc = v;
        end else if (i) begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic rt, input logic l,
                        input logic i, input logic [W-1:0] v);
        rst_s = r; call_s = c; ret_s = rt; ld_s = l; inc_s = i; din = v;
        @(posedge clk);
        model(r, c, rt, l, i, v);
        live = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("out",   32'(out_w),   32'(m_pc));
            chk("count", 32'(count_w), 32'(m_stk.size()));
            chk("full",  32'(full_w),  32'(m_stk.size() == D));
            chk("empty", 32'(empty_w), 32'(m_stk.size() == 0));
            chk("ovf",   32'(ovf_w),   32'(m_ovf));
            chk("unf",   32'(unf_w),   32'(m_unf));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset, then three increments
        step(1, 0, 0, 0, 0, '0);
        chk("lit_rst_out", 32'(out_w), 32'h0100);
        chk("lit_rst_empty", 32'(empty_w), 32'd1);
        chk("lit_rst_flags", {30'd0, ovf_w, unf_w}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 1, '0);
            chk("lit_inc_out", 32'(out_w), 32'h0100 + 32'(k));
        end
        chk("lit_inc_empty", 32'(empty_w), 32'd1);

        // call then ret
        step(0, 0, 0, 1, 0, 16'h0010);
        step(0, 1, 0, 0, 0, 16'h2000);
        chk("lit_call_out", 32'(out_w), 32'h2000);
        chk("lit_call_cnt", 32'(count_w), 32'd1);
        step(0, 0, 1, 0, 0, '0);
        chk("lit_ret_out", 32'(out_w), 32'h0011);
        chk("lit_ret_empty", 32'(empty_w), 32'd1);

        // fill, overflow, unwind
        for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0, 16'h3000 + 16'(k));
        chk("lit_full", 32'(full_w), 32'd1);
        step(0, 1, 0, 0, 0, 16'hBEEF);
        chk("lit_ovf_out", 32'(out_w), 32'h3007);
        chk("lit_ovf_cnt", 32'(count_w), 32'd8);
        chk("lit_ovf", 32'(ovf_w), 32'd1);
        for (int j = 0; j < 8; j++) begin
            step(0, 0, 1, 0, 0, '0);
            chk("lit_unwind", 32'(out_w), (j < 7) ? 32'h3007 - 32'(j) : 32'h0012);
        end

        // underflow, sticky
        step(0, 0, 1, 0, 0, '0);
        chk("lit_unf_out", 32'(out_w), 32'h0012);
        chk("lit_unf", 32'(unf_w), 32'd1);
        step(0, 0, 0, 0, 1, '0);
        chk("lit_unf_sticky", {30'd0, ovf_w, unf_w}, 32'd3);
        chk("lit_unf_inc", 32'(out_w), 32'h0013);
        step(0, 0, 0, 0, 0, 16'h7777);
        chk("lit_hold", 32'(out_w), 32'h0013);

        // simultaneous requests
        step(0, 0, 0, 1, 1, 16'h1234);
        chk("lit_ldinc", 32'(out_w), 32'h1234);
        step(0, 1, 0, 0, 0, 16'h4000);
        step(0, 1, 1, 0, 0, 16'h9999);
        chk("lit_callret_out", 32'(out_w), 32'h1235);
        chk("lit_callret_cnt", 32'(count_w), 32'd0);

        // wrap at all-ones
        step(0, 0, 0, 1, 0, 16'hFFFF);
        step(0, 0, 0, 0, 1, '0);
        chk("lit_wrap_inc", 32'(out_w), 32'h0000);
        step(0, 0, 0, 1, 0, 16'hFFFF);
        step(0, 1, 0, 0, 0, 16'h5000);
        step(0, 0, 1, 0, 0, '0);
        chk("lit_wrap_push", 32'(out_w), 32'h0000);

        // reset beats call mid-sequence
        step(0, 1, 0, 0, 0, 16'h0010);
        step(0, 1, 0, 0, 0, 16'h0020);
        step(0, 1, 0, 0, 0, 16'h0030);
        chk("lit_cnt3", 32'(count_w), 32'd3);
        step(1, 1, 0, 0, 0, 16'h0040);
        chk("lit_rst_call_out", 32'(out_w), 32'h0100);
        chk("lit_rst_call_cnt", 32'(count_w), 32'd0);
        chk("lit_rst_call_flags", {30'd0, ovf_w, unf_w}, 32'd0);

        // ret right after pop reaches zero
        step(0, 1, 0, 0, 0, 16'h0200);
        step(0, 0, 1, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);
        chk("lit_ret_at_zero_unf", 32'(unf_w), 32'd1);
        chk("lit_ret_at_zero_out", 32'(out_w), 32'h0101);

        step(0, 0, 0, 0, 0, '0);
        @(negedge clk);
        live = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated return-address stack for the CPU fetch path. It is the next generation of the fixed-width load register. It holds the current instruction address and supports hold, increment, load, call (push return address and jump) and return (pop and jump). Every update is synchronous to one clock, and stack overflow and underflow errors are reported as sticky flags.

## Interface
Parameters:
- WIDTH, 16, address/data width in bits
- DEPTH, 8, return-stack entries (power of two, ≥2)
- RESET_VEC, 0, value loaded into the PC on reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in  in  WIDTH  jump/call target
- ld  in  1  load PC from `in`
- inc  in  1  increment PC
- call  in  1  push PC+1, then PC <= `in`
- ret  in  1  PC <= top of stack, then pop
- out  out  WIDTH  current PC
- count  out  $clog2(DEPTH)+1  number of stack entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- ovf  out  1  sticky: call attempted while full
- unf  out  1  sticky: ret attempted while empty

## Operation
- Exactly one action per cycle, chosen by fixed priority:
  - reset > ret > call > ld > inc > hold
- reset:
  - out <= RESET_VEC, count <= 0
  - ovf <= 0, unf <= 0
  - stack RAM contents are not cleared and are don't-care
- ret:
  - if !empty: out <= stack[count-1], count <= count-1
  - if empty: out and count unchanged, unf <= 1
- call:
  - if !full: stack[count] <= out+1 (mod 2^WIDTH), out <= in, count <= count+1
  - if full: no push, out unchanged (no jump), ovf <= 1
- ld: out <= in
- inc: out <= out+1, wrapping from all-ones to 0
- hold: all state unchanged
- Simultaneous requests: lower-priority requests are ignored for that cycle.
  - call+ret → ret only
  - ld+inc → ld only
- ovf and unf stay set until reset; they never block later operations.
- full and empty are combinational decodes of registered count; they have no extra state.
- Arithmetic is modulo 2^WIDTH and carry is discarded, including the return address computed at PC = all-ones (pushes 0).

## Timing
- All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- Latency is 1 cycle: an action sampled at edge N is visible on out/count/flags after edge N.
- Back-to-back call then ret returns to the call-site PC+1 on the second cycle after the call edge, with no bubble.
- A ret in the same cycle that count reaches 0 (after a previous pop) sees empty=1 and sets unf.
- reset asserted mid-sequence (e.g. with call high) wins outright: no push, no flag update, out = RESET_VEC next cycle.
- Reset values: out=RESET_VEC, count=0, full=0, empty=1, ovf=0, unf=0.

## Structure
- Shared package `pc_pkg`:
  - action encoding constants ACT_HOLD, ACT_INC, ACT_LD, ACT_CALL, ACT_RET
  - the priority-select function returning the action
- Sub-module `reg_n`: a WIDTH-parametrised register with load enable and synchronous reset-to-value.
  - Used for the PC and for each stack entry; it generalises the existing 16-bit load register.
- Stack storage is DEPTH instances of `reg_n`, write-enabled by decoded stack pointer; the read mux is indexed by count-1.

## Test plan
- Reset then 3×inc with RESET_VEC=0x0100 → out = 0x0100, 0x0101, 0x0102, 0x0103; empty=1.
- out=0x0010, call in=0x2000; then ret → out=0x2000, count=1; then out=0x0011, count=0, empty=1.
- DEPTH=8: 8 calls → full=1; 9th call with in=0xBEEF → out unchanged, count=8, ovf=1; 8 rets unwind in LIFO order.
- ret while empty → out unchanged, unf=1; then inc → PC advances, unf stays 1 until reset.
- ld+inc with in=0x1234 → out=0x1234; call+ret with count=1 → pop only; inc at 0xFFFF → 0x0000; call at 0xFFFF → pushed 0x0000.
- reset asserted together with call while count=3 → next cycle out=RESET_VEC, count=0, ovf=unf=0.
